spi_slave_fsm: RTL and testbench

SPI_SLAVE_FSM -- requirements
Module: spi_slave_fsm

---
 rtl/spi_slave_fsm_if.sv | 25 ++
 rtl/spi_slave_fsm.sv | 147 ++++++++++++++
 tb/tb_spi_slave_fsm.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_fsm_if.sv
// SPI slave control bus: chip select, serial-clock edge pulses and the
// shift-register view in, shift-register mode, address and strobes out.
interface spi_slave_fsm_if;
    logic       csN;
    logic       sclkPosEdge;
    logic       sclkNegEdge;
    logic [7:0] shiftRegOut;
    logic [1:0] srMode;
    logic [6:0] addr;
    logic       addrLe;
    logic       memWe;
    logic       misoBufe;
    logic       abortPulse;
    logic       busy;

    modport slave (
        input  csN, sclkPosEdge, sclkNegEdge, shiftRegOut,
        output srMode, addr, addrLe, memWe, misoBufe, abortPulse, busy
    );

    modport master (
        output csN, sclkPosEdge, sclkNegEdge, shiftRegOut,
        input  srMode, addr, addrLe, memWe, misoBufe, abortPulse, busy
    );
endinterface

// File: rtl/spi_slave_fsm.sv
// SPI slave transaction controller. First byte carries a 7-bit address and
// a read/write flag in bit 0; a write then shifts in one data byte and
// strobes memWe, a read parallel-loads the shift register and drives MISO
// for eight falling serial-clock edges.
// Optional feature: define SPI_FSM_ABORT_DET_EN to drive abortPulse when a
// transaction is cut short by csN going high; otherwise abortPulse is 0.
module spi_slave_fsm (
    input  logic            clk,
    input  logic            resetN,
    spi_slave_fsm_if.slave  bus
);
    localparam logic [1:0] SR_HOLD  = 2'd0;
    localparam logic [1:0] SR_LEFT  = 2'd2;
    localparam logic [1:0] SR_PLOAD = 2'd3;

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, LATCH_ADDR, READ_LOAD,
        READ_SEND, WRITE_GET, WRITE_MEM, DONE
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] addr_q, addr_d;
    // Set once csN has been seen high since reset; a chip select that was
    // already low across a reset must not start a transaction.
    logic       armed_q;

    logic [1:0] sr_mode;
    logic       addr_le;
    logic       mem_we;
    logic       miso_bufe;
    logic       abort;
    logic       mid_state;

    // State, counter, address and arming registers with async reset
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            addr_q    <= 7'd0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            addr_q    <= addr_d;
            if (bus.csN) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign mid_state = (state_q != IDLE) && (state_q != DONE);

    // Next-state and output decode; an abort overrides every state action,
    // so a coincident counted edge and the state's strobes are dropped.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        addr_d    = addr_q;
        sr_mode   = SR_HOLD;
        addr_le   = 1'b0;
        mem_we    = 1'b0;
        miso_bufe = 1'b0;
        abort     = 1'b0;

        if (mid_state && bus.csN) begin
            abort     = 1'b1;
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!bus.csN && armed_q) begin
                        state_d   = GET_ADDR;
                        bit_cnt_d = 3'd0;
                    end
                end
                GET_ADDR: begin
                    sr_mode = SR_LEFT;
                    if (bus.sclkPosEdge) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = LATCH_ADDR;
                        end
                    end
                end
                LATCH_ADDR: begin
                    addr_le   = 1'b1;
                    addr_d    = bus.shiftRegOut[7:1];
                    bit_cnt_d = 3'd0;
                    state_d   = bus.shiftRegOut[0] ? READ_LOAD : WRITE_GET;
                end
                READ_LOAD: begin
                    sr_mode   = SR_PLOAD;
                    miso_bufe = 1'b1;
                    state_d   = READ_SEND;
                end
                READ_SEND: begin
                    sr_mode   = SR_LEFT;
                    miso_bufe = 1'b1;
                    if (bus.sclkNegEdge) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = DONE;
                        end
                    end
                end
                WRITE_GET: begin
                    sr_mode = SR_LEFT;
                    if (bus.sclkPosEdge) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = WRITE_MEM;
                        end
                    end
                end
                WRITE_MEM: begin
                    mem_we  = 1'b1;
                    state_d = DONE;
                end
                DONE: begin
                    if (bus.csN) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    bit_cnt_d = 3'd0;
                end
            endcase
        end
    end

    assign bus.srMode   = sr_mode;
    assign bus.addr     = addr_q;
    assign bus.addrLe   = addr_le;
    assign bus.memWe    = mem_we;
    assign bus.misoBufe = miso_bufe;
    assign bus.busy     = (state_q != IDLE);

`ifdef SPI_FSM_ABORT_DET_EN
    assign bus.abortPulse = abort;
`else
    assign bus.abortPulse = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Directed bench for spi_slave_fsm: write, read, abort, coincident abort,
// async reset mid-read and back-to-back transactions.
module tb_spi_slave_fsm;
    logic clk = 1'b0;
    logic resetN;
    int   tests = 0;
    int   fails = 0;

`ifdef SPI_FSM_ABORT_DET_EN
    localparam int ABORT_EXP = 1;
`else
    localparam int ABORT_EXP = 0;
`endif

    spi_slave_fsm_if bus ();

    spi_slave_fsm dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    // Per-cycle event tallies, sampled mid-cycle
    int n_addr_le = 0, n_mem_we = 0, n_pload = 0, n_abort = 0;
    int n_busy_low = 0, n_neg_in_miso = 0;
    always @(negedge clk) begin
        if (resetN) begin
            if (bus.addrLe)                          n_addr_le++;
            if (bus.memWe)                           n_mem_we++;
            if (bus.srMode == 2'd3)                  n_pload++;
            if (bus.abortPulse)                      n_abort++;
            if (!bus.busy)                           n_busy_low++;
            if (bus.misoBufe && bus.sclkNegEdge)     n_neg_in_miso++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the drive point of the next cycle
    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    // Send n bits of b (MSB first). The counted edge is pulsed for one clk,
    // then a gap clk carries the other edge, which the DUT must ignore. In
    // read mode the positive edge is also pulsed together with the counted one.
    task automatic send_bits(input logic [7:0] b, input int n, input bit use_neg);
        logic [7:0] sr;
        for (int i = 7; i > 7 - n; i--) begin
            if (use_neg) begin
                bus.sclkNegEdge = 1'b1;
                bus.sclkPosEdge = 1'b1;
            end else begin
                bus.sclkPosEdge = 1'b1;
            end
            nxt();
            bus.sclkNegEdge = 1'b0;
            bus.sclkPosEdge = 1'b0;
            if (!use_neg) begin
                sr = bus.shiftRegOut;
                bus.shiftRegOut = {sr[6:0], b[i]};
            end
            if (use_neg) bus.sclkPosEdge = 1'b1;
            else         bus.sclkNegEdge = 1'b1;
            nxt();
            bus.sclkNegEdge = 1'b0;
            bus.sclkPosEdge = 1'b0;
        end
    endtask

    int s_le, s_we, s_pl, s_ab, s_bl, s_neg;

    initial begin
        resetN          = 1'b0;
        bus.csN         = 1'b1;
        bus.sclkPosEdge = 1'b0;
        bus.sclkNegEdge = 1'b0;
        bus.shiftRegOut = 8'h00;

        // Reset state
        #3;
        chk("rst_busy",   {31'd0, bus.busy},       32'd0);
        chk("rst_srmode", {30'd0, bus.srMode},     32'd0);
        chk("rst_addr",   {25'd0, bus.addr},       32'd0);
        chk("rst_strobe", {29'd0, bus.addrLe, bus.memWe, bus.misoBufe}, 32'd0);
        chk("rst_abort",  {31'd0, bus.abortPulse}, 32'd0);
        nxt();
        resetN = 1'b1;
        nxt();
        nxt();

        // Write 0x54 (addr 0x2A, rw=0) then data 0xA5
        s_le = n_addr_le; s_we = n_mem_we;
        bus.csN = 1'b0;
        nxt();
        chk("wr_busy",     {31'd0, bus.busy},   32'd1);
        chk("wr_getaddr",  {30'd0, bus.srMode}, 32'd2);
        send_bits(8'h54, 8, 1'b0);
        chk("wr_addr",     {25'd0, bus.addr},   32'h2A);
        chk("wr_addrle",   n_addr_le - s_le,    32'd1);
        chk("wr_we_early", n_mem_we - s_we,     32'd0);
        send_bits(8'hA5, 8, 1'b0);
        chk("wr_memwe",    n_mem_we - s_we,     32'd1);
        chk("wr_done_busy",{31'd0, bus.busy},   32'd1);
        chk("wr_done_hold",{30'd0, bus.srMode}, 32'd0);
        $display("[TB] write addr=0x%0h data=0xA5", bus.addr);

        // Back-to-back: csN high for exactly one clk, then read 0x55
        s_bl = n_busy_low;
        bus.csN = 1'b1;
        nxt();
        bus.csN = 1'b0;
        nxt();
        chk("b2b_busy_low", n_busy_low - s_bl, 32'd1);
        s_le = n_addr_le; s_we = n_mem_we; s_pl = n_pload; s_neg = n_neg_in_miso;
        send_bits(8'h55, 8, 1'b0);
        chk("rd_pload",    {30'd0, bus.srMode},   32'd3);
        chk("rd_miso_ld",  {31'd0, bus.misoBufe}, 32'd1);
        chk("rd_addr",     {25'd0, bus.addr},     32'h2A);
        nxt();
        send_bits(8'h00, 8, 1'b1);
        chk("rd_neg_cnt",  n_neg_in_miso - s_neg, 32'd8);
        chk("rd_pload_cnt",n_pload - s_pl,        32'd1);
        chk("rd_addrle",   n_addr_le - s_le,      32'd1);
        chk("rd_no_we",    n_mem_we - s_we,       32'd0);
        chk("rd_done_miso",{31'd0, bus.misoBufe}, 32'd0);
        chk("rd_done_busy",{31'd0, bus.busy},     32'd1);
        $display("[TB] read addr=0x%0h", bus.addr);
        bus.csN = 1'b1;
        nxt();
        chk("rd_idle",     {31'd0, bus.busy},     32'd0);

        // Abort after 3 write-data bits
        s_we = n_mem_we; s_ab = n_abort;
        bus.csN = 1'b0;
        nxt();
        send_bits(8'h54, 8, 1'b0);
        send_bits(8'hFF, 3, 1'b0);
        bus.csN = 1'b1;
        #1;
        chk("ab_pulse_now",{31'd0, bus.abortPulse}, ABORT_EXP);
        nxt();
        chk("ab_idle",     {31'd0, bus.busy},     32'd0);
        nxt();
        chk("ab_no_we",    n_mem_we - s_we,       32'd0);
        chk("ab_pulse_cnt",n_abort - s_ab,        ABORT_EXP);
        chk("ab_addr_kept",{25'd0, bus.addr},     32'h2A);
        $display("[TB] write aborted after 3 data bits");

        // csN rises together with the 8th data edge: abort wins
        s_we = n_mem_we;
        bus.csN = 1'b0;
        nxt();
        send_bits(8'h3C, 8, 1'b0);
        chk("co_addr",     {25'd0, bus.addr},     32'h1E);
        send_bits(8'h81, 7, 1'b0);
        bus.sclkPosEdge = 1'b1;
        bus.csN = 1'b1;
        nxt();
        bus.sclkPosEdge = 1'b0;
        chk("co_idle",     {31'd0, bus.busy},     32'd0);
        nxt();
        nxt();
        chk("co_no_we",    n_mem_we - s_we,       32'd0);
        $display("[TB] write aborted on 8th data edge");

        // Async reset in the middle of READ_SEND, between clk edges
        bus.csN = 1'b0;
        nxt();
        send_bits(8'h55, 8, 1'b0);
        nxt();
        send_bits(8'h00, 3, 1'b1);
        chk("ar_pre_miso", {31'd0, bus.misoBufe}, 32'd1);
        #1;
        resetN = 1'b0;
        #1;
        chk("ar_busy",     {31'd0, bus.busy},     32'd0);
        chk("ar_miso",     {31'd0, bus.misoBufe}, 32'd0);
        chk("ar_srmode",   {30'd0, bus.srMode},   32'd0);
        chk("ar_addr",     {25'd0, bus.addr},     32'd0);
        nxt();
        resetN = 1'b1;
        nxt();
        nxt();
        nxt();
        chk("ar_no_restart",{31'd0, bus.busy},    32'd0);
        bus.csN = 1'b1;
        nxt();
        bus.csN = 1'b0;
        nxt();
        chk("ar_restart",  {31'd0, bus.busy},     32'd1);
        bus.csN = 1'b1;
        nxt();
        chk("ar_end_idle", {31'd0, bus.busy},     32'd0);
        $display("[TB] read interrupted by reset, new transaction started");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
